axi4_slave_write_responder: RTL and testbench

- Synthesizable AXI4 write-channel responder (slave end) in front of a byte-addressed local memory.
- Serves as the DUT-side counterpart for the AXI4 master agent's write path.
- Accepts an AW request, consumes the W burst into memory with strobes, then returns one B response.
- One outstanding transaction; the read channel is out of scope.

---
 rtl/axi4_slave_write_responder_pkg.sv | 44 ++++
 rtl/axi4_burst_addr_gen.sv | 48 ++++
 rtl/axi4_slave_write_responder.sv | 178 +++++++++++++++++
 tb/tb_axi4_slave_write_responder.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_slave_write_responder_pkg.sv
// rtl/axi4_slave_write_responder_pkg.sv - shared AXI4 write-path types, widths and helpers
package axi4_slave_write_responder_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 64;

  typedef enum logic [1:0] {
    BURST_FIXED    = 2'b00,
    BURST_INCR     = 2'b01,
    BURST_WRAP     = 2'b10,
    BURST_RESERVED = 2'b11
  } awburst_e;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } awsize_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } bresp_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// rtl/axi4_burst_addr_gen.sv - per-beat byte address and active lane window for an AXI4 burst
module axi4_burst_addr_gen #(
  parameter int ADDRESS_WIDTH = axi4_slave_write_responder_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = axi4_slave_write_responder_pkg::DATA_WIDTH,
  parameter int LANE_W        = ((DATA_WIDTH / 8) > 1) ? $clog2(DATA_WIDTH / 8) : 1
) (
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [2:0]               size,
  input  logic [7:0]               len,
  input  logic [1:0]               burst,
  input  logic [7:0]               beat,
  output logic [ADDRESS_WIDTH-1:0] beat_addr,
  output logic [LANE_W-1:0]        lo_lane,
  output logic [LANE_W-1:0]        hi_lane
);
  import axi4_slave_write_responder_pkg::*;

  localparam int BUS = DATA_WIDTH / 8;

  logic [ADDRESS_WIDTH-1:0] size_bytes;
  logic [ADDRESS_WIDTH-1:0] step;
  logic [ADDRESS_WIDTH-1:0] aligned;
  logic [ADDRESS_WIDTH-1:0] wrap_bytes;
  logic [ADDRESS_WIDTH-1:0] wrap_base;
  logic [ADDRESS_WIDTH-1:0] wrap_off;
  logic [LANE_W-1:0]        lane_mask;

  // Address for beat k, then the lane window [lo, hi] that beat may touch on the bus
  always_comb begin
    size_bytes = ADDRESS_WIDTH'(1) << size;
    step       = ADDRESS_WIDTH'(beat) << size;
    aligned    = start_addr & ~(size_bytes - ADDRESS_WIDTH'(1));
    wrap_bytes = (ADDRESS_WIDTH'(len) + ADDRESS_WIDTH'(1)) << size;
    wrap_base  = start_addr & ~(wrap_bytes - ADDRESS_WIDTH'(1));
    wrap_off   = (start_addr + step) & (wrap_bytes - ADDRESS_WIDTH'(1));
    case (awburst_e'(burst))
      BURST_FIXED: beat_addr = start_addr;
      BURST_INCR:  beat_addr = (beat == 8'd0) ? start_addr : aligned + step;
      BURST_WRAP:  beat_addr = wrap_base + wrap_off;
      default:     beat_addr = start_addr;
    endcase
    // An unaligned first beat starts mid-container; the container always ends at the size boundary
    lane_mask = LANE_W'(size_bytes - ADDRESS_WIDTH'(1)) & LANE_W'(BUS - 1);
    lo_lane   = beat_addr[LANE_W-1:0] & LANE_W'(BUS - 1);
    hi_lane   = (lo_lane & ~lane_mask) + lane_mask;
  end

endmodule

// File: rtl/axi4_slave_write_responder.sv
// rtl/axi4_slave_write_responder.sv - single-outstanding AXI4 write responder over a byte memory
module axi4_slave_write_responder #(
  parameter int ADDRESS_WIDTH = axi4_slave_write_responder_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = axi4_slave_write_responder_pkg::DATA_WIDTH,
  parameter int ID_WIDTH      = 4,
  parameter int MEM_BYTES     = 4096
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ID_WIDTH-1:0]       awid,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awlock,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [ID_WIDTH-1:0]       bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDRESS_WIDTH-1:0]  dbg_addr,
  output logic [7:0]                dbg_data
);
  import axi4_slave_write_responder_pkg::*;

  localparam int BUS     = DATA_WIDTH / 8;
  localparam int BUS_LOG = $clog2(BUS);
  localparam int LW      = (BUS > 1) ? $clog2(BUS) : 1;
  localparam int MW      = $clog2(MEM_BYTES);

  wr_state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]      id_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [7:0]               len_q;
  awsize_e                  size_q;
  logic [1:0]               burst_q;
  logic [7:0]               beat_q;
  logic                     req_err_q;
  logic                     slverr_q;
  logic                     decerr_q;

  logic                     aw_hs, w_hs, b_hs;
  logic                     last_beat;
  logic                     misaligned;
  logic                     req_err;
  logic [ADDRESS_WIDTH-1:0] beat_addr;
  logic [LW-1:0]            lo_lane, hi_lane;
  logic                     beat_oob;
  logic [MW-1:0]            word_base;
  logic [BUS-1:0]           lane_we;
  logic [7:0]               mem [MEM_BYTES];
  logic                     unused_awlock;

  // Exclusive access is not supported, so the lock bit has no effect
  assign unused_awlock = awlock;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign b_hs      = bvalid && bready;
  assign last_beat = (beat_q == len_q);
  assign bid       = id_q;

  assign misaligned = (awaddr & ((ADDRESS_WIDTH'(1) << awsize) - ADDRESS_WIDTH'(1))) != '0;
  assign req_err    = (awburst == BURST_RESERVED)
                   || (awsize > 3'(BUS_LOG))
                   || ((awburst == BURST_WRAP) && (!wrap_len_ok(awlen) || misaligned));

  axi4_burst_addr_gen #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .LANE_W        (LW)
  ) u_addr_gen (
    .start_addr (addr_q),
    .size       (size_q),
    .len        (len_q),
    .burst      (burst_q),
    .beat       (beat_q),
    .beat_addr  (beat_addr),
    .lo_lane    (lo_lane),
    .hi_lane    (hi_lane)
  );

  assign beat_oob  = beat_addr >= ADDRESS_WIDTH'(MEM_BYTES);
  assign word_base = beat_addr[MW-1:0] & ~MW'(BUS - 1);

  // State register; reset lands in INIT so awready stays low for one cycle after release
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_INIT;
    else          state_q <= state_d;
  end

  // Next-state: one request at a time, DATA ends on the len-th beat regardless of wlast
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: if (aw_hs) state_d = ST_DATA;
      ST_DATA: if (w_hs && last_beat) state_d = ST_RESP;
      ST_RESP: if (b_hs) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // Channel handshakes and response code follow the state directly
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = RESP_OKAY;
    case (state_q)
      ST_IDLE: awready = 1'b1;
      ST_DATA: wready  = 1'b1;
      ST_RESP: begin
        bvalid = 1'b1;
        if (decerr_q)      bresp = RESP_DECERR;
        else if (slverr_q) bresp = RESP_SLVERR;
        else               bresp = RESP_OKAY;
      end
      default: ;
    endcase
  end

  // Request capture, beat counting and error accumulation for the response
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= SIZE_1B;
      burst_q   <= '0;
      beat_q    <= '0;
      req_err_q <= 1'b0;
      slverr_q  <= 1'b0;
      decerr_q  <= 1'b0;
    end else if (aw_hs) begin
      id_q      <= awid;
      addr_q    <= awaddr;
      len_q     <= awlen;
      size_q    <= awsize_e'(awsize);
      burst_q   <= awburst;
      beat_q    <= '0;
      req_err_q <= req_err;
      slverr_q  <= req_err;
      decerr_q  <= 1'b0;
    end else if (w_hs) begin
      beat_q <= beat_q + 8'd1;
      if (wlast != last_beat) slverr_q <= 1'b1;
      // A rejected request never decodes its addresses, so it cannot raise DECERR
      if (!req_err_q && beat_oob) decerr_q <= 1'b1;
    end
  end

  // Per-lane write enables: strobe set, inside the beat's lane window, request accepted, address in range
  always_comb begin
    lane_we = '0;
    if (w_hs && !req_err_q && !beat_oob) begin
      for (int i = 0; i < BUS; i++) begin
        lane_we[i] = wstrb[i] && (LW'(i) >= lo_lane) && (LW'(i) <= hi_lane);
      end
    end
  end

  // Memory array is deliberately left out of reset
  always_ff @(posedge aclk) begin
    for (int i = 0; i < BUS; i++) begin
      if (lane_we[i]) mem[word_base | MW'(i)] <= wdata[8*i +: 8];
    end
  end

  assign dbg_data = (dbg_addr < ADDRESS_WIDTH'(MEM_BYTES)) ? mem[dbg_addr[MW-1:0]] : 8'h00;

endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// tb/tb_axi4_slave_write_responder.sv - self-checking bench for axi4_slave_write_responder
module tb_axi4_slave_write_responder;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int MEM = 4096;
  localparam int BUS = DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [IW-1:0] awid = '0;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic          awlock = 1'b0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [BUS-1:0] wstrb = '0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [7:0]    dbg_data;

  int total = 0;
  int bad = 0;

  logic [7:0]     model_mem [MEM];
  logic [DW-1:0]  beat_data [256];
  logic [BUS-1:0] beat_strb [256];

  axi4_slave_write_responder #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .ID_WIDTH      (IW),
    .MEM_BYTES     (MEM)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .awid     (awid),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awburst  (awburst),
    .awlock   (awlock),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bid      (bid),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic bit drv_wlast(input int mode, input int k, input int len);
    if (mode == 1 && k == 0) return 1'b1;
    if (mode == 2) return 1'b0;
    return (k == len);
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] start, input int size,
                                             input int len, input int burst, input int k);
    longint unsigned sb, wb, a, s;
    s  = longint'(start);
    sb = 64'd1 << size;
    case (burst)
      1: a = (k == 0) ? s : (s / sb) * sb + longint'(k) * sb;
      2: begin
        wb = sb * longint'(len + 1);
        a  = (s / wb) * wb + ((s + longint'(k) * sb) % wb);
      end
      default: a = s;
    endcase
    return a[31:0];
  endfunction

  task automatic model_burst(input logic [31:0] start, input int len, input int size,
                             input int burst, input int last_mode, output logic [1:0] exp_rsp);
    bit req_err, wl_err, dec;
    longint unsigned sb, a, lo, hi;
    sb = 64'd1 << size;
    req_err = (burst == 3) || (sb > BUS)
           || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
           || (burst == 2 && (longint'(start) % sb) != 0);
    wl_err = 1'b0;
    dec = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (drv_wlast(last_mode, k, len) != (k == len)) wl_err = 1'b1;
      if (!req_err) begin
        a = longint'(model_addr(start, size, len, burst, k));
        if (a >= MEM) dec = 1'b1;
        else begin
          lo = a % BUS;
          hi = ((a / sb * sb) % BUS) + sb - 1;
          for (int i = 0; i < BUS; i++) begin
            if (beat_strb[k][i] && i >= lo && i <= hi)
              model_mem[(a / BUS) * BUS + i] = beat_data[k][8*i +: 8];
          end
        end
      end
    end
    exp_rsp = dec ? 2'b11 : ((req_err || wl_err) ? 2'b10 : 2'b00);
  endtask

  task automatic peek(input logic [31:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic run_burst(input logic [IW-1:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int last_mode, input int hold,
                           output logic [1:0] rsp, output logic [IW-1:0] rid,
                           output bit lat_ok, output bit stable_ok, output bit tmo);
    int cyc;
    tmo = 1'b0;
    stable_ok = 1'b1;
    @(posedge aclk); #1;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    cyc = 0;
    @(negedge aclk);
    while (!awready && cyc < 50) begin @(negedge aclk); cyc++; end
    if (!awready) tmo = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      wvalid = 1'b1;
      wdata  = beat_data[k];
      wstrb  = beat_strb[k];
      wlast  = drv_wlast(last_mode, k, len);
      cyc = 0;
      @(negedge aclk);
      while (!wready && cyc < 50) begin @(negedge aclk); cyc++; end
      if (!wready) tmo = 1'b1;
      @(posedge aclk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    @(negedge aclk);
    lat_ok = bvalid;
    rsp = bresp;
    rid = bid;
    for (int h = 0; h < hold; h++) begin
      if (!bvalid || bresp !== rsp || bid !== rid || awready) stable_ok = 1'b0;
      @(negedge aclk);
    end
    bready = 1'b1;
    cyc = 0;
    while (!bvalid && cyc < 50) begin @(negedge aclk); cyc++; end
    if (!bvalid) tmo = 1'b1;
    rsp = bresp;
    rid = bid;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge aclk);
    total++; if (awready !== 1'b0) begin bad++; $display("FAIL reset_awready got=%b exp=0", awready); end
    total++; if (wready !== 1'b0) begin bad++; $display("FAIL reset_wready got=%b exp=0", wready); end
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL reset_bvalid got=%b exp=0", bvalid); end
    total++; if (bid !== 4'h0 || bresp !== 2'b00) begin bad++; $display("FAIL reset_b got bid=%h bresp=%b exp 0/00", bid, bresp); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    total++; if (awready !== 1'b0) begin bad++; $display("FAIL init_awready got=%b exp=0", awready); end
    @(negedge aclk);
    total++; if (awready !== 1'b1) begin bad++; $display("FAIL idle_awready got=%b exp=1", awready); end
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL idle_bvalid got=%b exp=0", bvalid); end
  endtask

  task automatic test_fill();
    logic [1:0] rsp, exp;
    logic [IW-1:0] rid;
    bit lat_ok, st_ok, tmo;
    for (int j = 0; j < MEM / 128; j++) begin
      for (int k = 0; k < 16; k++) begin
        beat_data[k] = {$urandom, $urandom};
        beat_strb[k] = '1;
      end
      model_burst(32'(j * 128), 15, 3, 1, 0, exp);
      run_burst(4'(j), 32'(j * 128), 15, 3, 1, 0, 0, rsp, rid, lat_ok, st_ok, tmo);
      total++; if (rsp !== exp || tmo) begin bad++; $display("FAIL fill_bresp j=%0d got=%b exp=%b tmo=%0d", j, rsp, exp, tmo); end
    end
  endtask

  task automatic test_incr();
    logic [1:0] rsp, exp;
    logic [IW-1:0] rid;
    logic [7:0] d;
    bit lat_ok, st_ok, tmo;
    logic [7:0] pat [4];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    for (int k = 0; k < 4; k++) begin
      beat_data[k] = {8{pat[k]}};
      beat_strb[k] = '1;
    end
    model_burst(32'h100, 3, 3, 1, 0, exp);
    run_burst(4'h5, 32'h100, 3, 3, 1, 0, 0, rsp, rid, lat_ok, st_ok, tmo);
    total++; if (rsp !== 2'b00) begin bad++; $display("FAIL incr_bresp got=%b exp=00", rsp); end
    total++; if (rid !== 4'h5) begin bad++; $display("FAIL incr_bid got=%h exp=5", rid); end
    total++; if (!lat_ok || tmo) begin bad++; $display("FAIL incr_latency got lat_ok=%0d tmo=%0d exp 1/0", lat_ok, tmo); end
    for (int b = 0; b < 32; b++) begin
      peek(32'h100 + 32'(b), d);
      total++; if (d !== pat[b / 8]) begin bad++; $display("FAIL incr_byte addr=%h got=%h exp=%h", 32'h100 + b, d, pat[b / 8]); end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] rsp, exp;
    logic [IW-1:0] rid;
    logic [7:0] d;
    bit lat_ok, st_ok, tmo;
    logic [31:0] hit [4];
    hit[0] = 32'h38; hit[1] = 32'h20; hit[2] = 32'h28; hit[3] = 32'h30;
    for (int k = 0; k < 4; k++) begin
      beat_data[k] = {8{8'(8'hA0 + k)}};
      beat_strb[k] = '1;
    end
    model_burst(32'h38, 3, 3, 2, 0, exp);
    run_burst(4'h9, 32'h38, 3, 3, 2, 0, 0, rsp, rid, lat_ok, st_ok, tmo);
    total++; if (rsp !== 2'b00 || rid !== 4'h9) begin bad++; $display("FAIL wrap_b got bresp=%b bid=%h exp 00/9", rsp, rid); end
    for (int k = 0; k < 4; k++) begin
      peek(hit[k] + 32'(k % 8), d);
      total++; if (d !== 8'(8'hA0 + k)) begin bad++; $display("FAIL wrap_beat k=%0d addr=%h got=%h exp=%h", k, hit[k], d, 8'hA0 + k); end
    end
  endtask

  task automatic test_narrow();
    logic [1:0] rsp, exp;
    logic [IW-1:0] rid;
    logic [7:0] d;
    logic [7:0] keep202, keep205;
    bit lat_ok, st_ok, tmo;
    keep202 = model_mem[32'h202];
    keep205 = model_mem[32'h205];
    beat_data[0] = {8{8'hAA}}; beat_strb[0] = '1;
    beat_data[1] = {8{8'hBB}}; beat_strb[1] = '1;
    model_burst(32'h203, 1, 0, 1, 0, exp);
    run_burst(4'h3, 32'h203, 1, 0, 1, 0, 0, rsp, rid, lat_ok, st_ok, tmo);
    total++; if (rsp !== 2'b00) begin bad++; $display("FAIL narrow_bresp got=%b exp=00", rsp); end
    peek(32'h203, d);
    total++; if (d !== 8'hAA) begin bad++; $display("FAIL narrow_203 got=%h exp=aa", d); end
    peek(32'h204, d);
    total++; if (d !== 8'hBB) begin bad++; $display("FAIL narrow_204 got=%h exp=bb", d); end
    peek(32'h202, d);
    total++; if (d !== keep202) begin bad++; $display("FAIL narrow_202 got=%h exp=%h", d, keep202); end
    peek(32'h205, d);
    total++; if (d !== keep205) begin bad++; $display("FAIL narrow_205 got=%h exp=%h", d, keep205); end
  endtask

  task automatic test_reserved();
    logic [1:0] rsp, exp;
    logic [IW-1:0] rid;
    logic [7:0] d, keep;
    bit lat_ok, st_ok, tmo;
    keep = model_mem[32'h400];
    beat_data[0] = {8{8'h5A}}; beat_strb[0] = '1;
    beat_data[1] = {8{8'h5A}}; beat_strb[1] = '1;
    model_burst(32'h400, 1, 3, 3, 0, exp);
    run_burst(4'hC, 32'h400, 1, 3, 3, 0, 0, rsp, rid, lat_ok, st_ok, tmo);
    total++; if (rsp !== 2'b10) begin bad++; $display("FAIL reserved_bresp got=%b exp=10", rsp); end
    peek(32'h400, d);
    total++; if (d !== keep) begin bad++; $display("FAIL reserved_nowrite got=%h exp=%h", d, keep); end
  endtask

  task automatic test_decerr();
    logic [1:0] rsp, exp;
    logic [IW-1:0] rid;
    logic [7:0] d;
    bit lat_ok, st_ok, tmo;
    beat_data[0] = {8{8'hC3}}; beat_strb[0] = '1;
    beat_data[1] = {8{8'h3C}}; beat_strb[1] = '1;
    model_burst(32'(MEM - 8), 1, 3, 1, 0, exp);
    run_burst(4'h7, 32'(MEM - 8), 1, 3, 1, 0, 0, rsp, rid, lat_ok, st_ok, tmo);
    total++; if (rsp !== 2'b11) begin bad++; $display("FAIL decerr_bresp got=%b exp=11", rsp); end
    peek(32'(MEM - 1), d);
    total++; if (d !== 8'hC3) begin bad++; $display("FAIL decerr_first_beat got=%h exp=c3", d); end
  endtask

  task automatic test_wlast();
    logic [1:0] rsp, exp;
    logic [IW-1:0] rid;
    bit lat_ok, st_ok, tmo;
    for (int k = 0; k < 3; k++) begin beat_data[k] = {$urandom, $urandom}; beat_strb[k] = '1; end
    model_burst(32'h500, 2, 3, 1, 1, exp);
    run_burst(4'h2, 32'h500, 2, 3, 1, 1, 0, rsp, rid, lat_ok, st_ok, tmo);
    total++; if (rsp !== 2'b10) begin bad++; $display("FAIL wlast_bresp got=%b exp=10", rsp); end
    total++; if (!lat_ok || tmo) begin bad++; $display("FAIL wlast_three_beats got lat_ok=%0d tmo=%0d exp 1/0", lat_ok, tmo); end
  endtask

  task automatic test_backpressure();
    logic [1:0] rsp, exp;
    logic [IW-1:0] rid;
    bit lat_ok, st_ok, tmo;
    for (int k = 0; k < 2; k++) begin beat_data[k] = {$urandom, $urandom}; beat_strb[k] = '1; end
    model_burst(32'h600, 1, 3, 1, 0, exp);
    run_burst(4'hE, 32'h600, 1, 3, 1, 0, 5, rsp, rid, lat_ok, st_ok, tmo);
    total++; if (!st_ok) begin bad++; $display("FAIL bp_stable got=0 exp=1"); end
    total++; if (rsp !== 2'b00 || rid !== 4'hE) begin bad++; $display("FAIL bp_b got bresp=%b bid=%h exp 00/e", rsp, rid); end
    @(negedge aclk);
    total++; if (awready !== 1'b1 || bvalid !== 1'b0) begin bad++; $display("FAIL bp_idle got awready=%b bvalid=%b exp 1/0", awready, bvalid); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] rsp, exp;
    logic [IW-1:0] rid;
    bit lat_ok, st_ok, tmo;
    int cyc;
    @(posedge aclk); #1;
    awid = 4'h1; awaddr = 32'h700; awlen = 8'd3; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    cyc = 0;
    @(negedge aclk);
    while (!awready && cyc < 50) begin @(negedge aclk); cyc++; end
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b1; wstrb = '0; wdata = '1; wlast = 1'b0;
    @(negedge aclk);
    total++; if (wready !== 1'b1) begin bad++; $display("FAIL mid_wready got=%b exp=1", wready); end
    @(posedge aclk); #1;
    aresetn = 1'b0;
    wvalid = 1'b0;
    @(negedge aclk);
    total++; if (bvalid !== 1'b0 || wready !== 1'b0 || awready !== 1'b0) begin bad++; $display("FAIL mid_reset got bvalid=%b wready=%b awready=%b exp 0/0/0", bvalid, wready, awready); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    total++; if (awready !== 1'b1 || bvalid !== 1'b0) begin bad++; $display("FAIL mid_resume got awready=%b bvalid=%b exp 1/0", awready, bvalid); end
    for (int k = 0; k < 2; k++) begin beat_data[k] = {$urandom, $urandom}; beat_strb[k] = '1; end
    model_burst(32'h700, 1, 3, 1, 0, exp);
    run_burst(4'h4, 32'h700, 1, 3, 1, 0, 0, rsp, rid, lat_ok, st_ok, tmo);
    total++; if (rsp !== exp || rid !== 4'h4 || tmo) begin bad++; $display("FAIL mid_after got bresp=%b bid=%h exp %b/4", rsp, rid, exp); end
  endtask

  task automatic test_random();
    logic [1:0] rsp, exp;
    logic [IW-1:0] rid, id;
    logic [31:0] addr;
    bit lat_ok, st_ok, tmo;
    int len, size, burst, lm, r;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      burst = (r == 0) ? 3 : (r <= 3 ? 0 : (r <= 6 ? 1 : 2));
      size = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
      if (burst == 2 && $urandom_range(0, 4) != 0) begin
        r = $urandom_range(0, 3);
        len = (r == 0) ? 1 : (r == 1 ? 3 : (r == 2 ? 7 : 15));
      end else begin
        len = $urandom_range(0, 7);
      end
      r = $urandom_range(0, 9);
      if (r <= 6)      addr = 32'($urandom_range(0, MEM - 1));
      else if (r <= 8) addr = 32'(MEM - 64 + $urandom_range(0, 127));
      else             addr = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
      if (burst == 2 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      r = $urandom_range(0, 9);
      lm = (r == 0) ? 1 : (r == 1 ? 2 : 0);
      id = 4'($urandom);
      for (int k = 0; k <= len; k++) begin
        beat_data[k] = {$urandom, $urandom};
        beat_strb[k] = 8'($urandom);
      end
      model_burst(addr, len, size, burst, lm, exp);
      run_burst(id, addr, len, size, burst, lm, 0, rsp, rid, lat_ok, st_ok, tmo);
      total++; if (rsp !== exp) begin bad++; $display("FAIL rand_bresp n=%0d addr=%h len=%0d size=%0d burst=%0d got=%b exp=%b", n, addr, len, size, burst, rsp, exp); end
      total++; if (rid !== id) begin bad++; $display("FAIL rand_bid n=%0d got=%h exp=%h", n, rid, id); end
      total++; if (!lat_ok || tmo) begin bad++; $display("FAIL rand_latency n=%0d got lat_ok=%0d tmo=%0d exp 1/0", n, lat_ok, tmo); end
    end
  endtask

  task automatic test_mem_sweep();
    logic [7:0] d;
    int errs;
    errs = 0;
    for (int a = 0; a < MEM; a++) begin
      peek(32'(a), d);
      if (d !== model_mem[a]) begin
        if (errs == 0) $display("FAIL mem_sweep addr=%h got=%h exp=%h", a, d, model_mem[a]);
        errs++;
      end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL mem_sweep_count got=%0d exp=0", errs); end
    peek(32'(MEM), d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL dbg_oob got=%h exp=00", d); end
    peek(32'hFFFF_FFFF, d);
    total++; if (d !== 8'h00) begin bad++; $display("FAIL dbg_oob_top got=%h exp=00", d); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_incr();
    test_wrap();
    test_narrow();
    test_reserved();
    test_decerr();
    test_wlast();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_mem_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
